// File: rtl/hub75_receiver.sv
// ---------------------------------------------------------------------------
// hub75_receiver: samples a HUB75 panel bus and replays each latched line as pixel writes.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hub75_receiver #(
  parameter int COLS        = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_data_clock,
  input  logic                    i_data_latch,
  input  logic                    i_data_blank,
  input  logic [1:0]              i_data_r,
  input  logic [1:0]              i_data_g,
  input  logic [1:0]              i_data_b,
  input  logic [4:0]              i_row_select,
  output logic                    o_wr_valid,
  input  logic                    i_wr_ready,
  output logic [4:0]              o_wr_row,
  output logic [$clog2(COLS)-1:0] o_wr_col,
  output logic [5:0]              o_wr_data,
  output logic                    o_blank,
  output logic                    o_overrun,
  output logic                    o_framing_err
);

  localparam int CW = $clog2(COLS);
  localparam int NW = $clog2(COLS + 1);
  localparam int PW = 14;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  localparam logic [NW-1:0] c_COLS = NW'(COLS);
  localparam logic [CW-1:0] c_LAST = CW'(COLS - 1);

  // Pin bundle: {clock, latch, blank, colour[5:0], row[4:0]}
  logic [PW-1:0] pins;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] s;
  logic [1:0]    edge_q;
  logic          clk_rise;
  logic          lat_rise;
  logic [5:0]    colour;
  logic [4:0]    row_s;

  logic [NW-1:0] col_cnt_q, col_cnt_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [0:0]    state_q, state_d;
  logic [4:0]    row_q, row_d;
  logic          ovr_q, ovr_d;
  logic          frm_q, frm_d;
  logic          commit;

  logic [5:0]    line_q [COLS];
  logic [5:0]    rd_buf_q [COLS];

  assign pins = {i_data_clock, i_data_latch, i_data_blank,
                 i_data_r[1], i_data_g[1], i_data_b[1],
                 i_data_r[0], i_data_g[0], i_data_b[0],
                 i_row_select};

  assign s        = sync_q[SYNC_STAGES-1];
  assign clk_rise = s[13] & ~edge_q[1];
  assign lat_rise = s[12] & ~edge_q[0];
  assign colour   = s[10:5];
  assign row_s    = s[4:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= s[13:12];
    end
  end

  always_comb begin
    col_cnt_d = col_cnt_q;
    rd_col_d  = rd_col_q;
    state_d   = state_q;
    row_d     = row_q;
    ovr_d     = ovr_q;
    frm_d     = frm_q;
    commit    = 1'b0;

    if (clk_rise) begin
      if (col_cnt_q == c_COLS) frm_d = 1'b1;
      else                     col_cnt_d = col_cnt_q + NW'(1);
    end

    if (state_q == S_SEND && i_wr_ready) begin
      if (rd_col_q == c_LAST) state_d = S_IDLE;
      else                    rd_col_d = rd_col_q + CW'(1);
    end

    // Still in S_SEND on the final handshake cycle, so a coincident latch is dropped.
    if (lat_rise) begin
      col_cnt_d = '0;
      if (col_cnt_q != c_COLS) frm_d = 1'b1;
      if (state_q == S_IDLE) begin
        commit   = 1'b1;
        state_d  = S_SEND;
        rd_col_d = '0;
        row_d    = row_s;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt_q <= '0;
      rd_col_q  <= '0;
      state_q   <= S_IDLE;
      row_q     <= '0;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      rd_col_q  <= rd_col_d;
      state_q   <= state_d;
      row_q     <= row_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (clk_rise && col_cnt_q != c_COLS) line_q[col_cnt_q[CW-1:0]] <= colour;
    if (commit) begin
      for (int i = 0; i < COLS; i++) rd_buf_q[i] <= line_q[i];
    end
  end

  assign o_wr_valid    = (state_q == S_SEND);
  assign o_wr_row      = row_q;
  assign o_wr_col      = rd_col_q;
  assign o_wr_data     = o_wr_valid ? rd_buf_q[rd_col_q] : 6'd0;
  assign o_blank       = s[11];
  assign o_overrun     = ovr_q;
  assign o_framing_err = frm_q;

endmodule

`default_nettype wire

// File: tb/tb_hub75_receiver.sv
// ---------------------------------------------------------------------------
// tb_hub75_receiver: directed line patterns against a queue of hand-derived expected writes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_hub75_receiver;

  localparam int COLS = 20;
  localparam int CW   = $clog2(COLS);

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          dclk    = 1'b0;
  logic          latch   = 1'b0;
  logic          blank   = 1'b0;
  logic [1:0]    r       = '0;
  logic [1:0]    g       = '0;
  logic [1:0]    b       = '0;
  logic [4:0]    row_sel = '0;
  logic          wr_ready = 1'b0;

  logic          wr_valid;
  logic [4:0]    wr_row;
  logic [CW-1:0] wr_col;
  logic [5:0]    wr_data;
  logic          o_blank;
  logic          overrun;
  logic          framing;

  int            n_tot = 0;
  int            n_bad = 0;
  int            rdy_mode = 1;
  int            rdy_cnt = 0;
  logic [15:0]   exp_q [$];
  logic [5:0]    line_m [COLS];
  logic          stalled = 1'b0;
  logic [15:0]   held = '0;

  always #5 clk = ~clk;

  hub75_receiver #(.COLS(COLS), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_clock (dclk),
    .i_data_latch (latch),
    .i_data_blank (blank),
    .i_data_r     (r),
    .i_data_g     (g),
    .i_data_b     (b),
    .i_row_select (row_sel),
    .o_wr_valid   (wr_valid),
    .i_wr_ready   (wr_ready),
    .o_wr_row     (wr_row),
    .o_wr_col     (wr_col),
    .o_wr_data    (wr_data),
    .o_blank      (o_blank),
    .o_overrun    (overrun),
    .o_framing_err(framing)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Sink ready pattern: 0 = stalled, 1 = always ready, 2 = ready one cycle in three
  always begin
    @(negedge clk);
    rdy_cnt = rdy_cnt + 1;
    case (rdy_mode)
      0:       wr_ready = 1'b0;
      1:       wr_ready = 1'b1;
      default: wr_ready = (rdy_cnt % 3 == 0);
    endcase
  end

  // Write monitor: each accepted write must match the head of the expected queue
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", wr_valid, 1);
        chk("stall_hold", {wr_row, wr_col, wr_data}, held);
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) chk("extra_write", {wr_row, wr_col, wr_data}, 32'hFFFF_FFFF);
        else                   chk("write", {wr_row, wr_col, wr_data}, exp_q.pop_front());
      end
      stalled = wr_valid && !wr_ready;
      held    = {wr_row, wr_col, wr_data};
    end
  end

  task automatic set_colour(input logic [5:0] d);
    r = {d[5], d[2]};
    g = {d[4], d[1]};
    b = {d[3], d[0]};
  endtask

  // Shift n pixels (colour = c*mul+base mod 64), then latch the row with blank high
  task automatic send_line(input logic [4:0] row, input int n, input int mul,
                           input int base, input bit commit);
    logic [5:0] d;
    for (int c = 0; c < n; c++) begin
      d = 6'((c * mul + base) & 63);
      step(); set_colour(d); dclk = 1'b0;
      step(); dclk = 1'b1;
      if (c < COLS) line_m[c] = d;
    end
    step(); dclk = 1'b0;
    step(); blank = 1'b1; latch = 1'b1; row_sel = row;
    step(); #1; chk("blank_lag", o_blank, 0); latch = 1'b0;
    step(); #1; chk("blank_on", o_blank, 1); blank = 1'b0;
    if (commit) begin
      for (int c = 0; c < COLS; c++) exp_q.push_back({row, CW'(c), line_m[c]});
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    step(); #2;
    while ((exp_q.size() != 0 || wr_valid) && k < 1000) begin
      step(); #2;
      k++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_idle"}, wr_valid, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; dclk = 1'b0; latch = 1'b0; blank = 1'b0;
    step(); step();
    exp_q.delete();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int  k;
    bit  found;

    rst_n = 1'b0;
    step(); step(); #1;
    chk("rst_valid", wr_valid, 0);
    chk("rst_row", wr_row, 0);
    chk("rst_col", wr_col, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_blank", o_blank, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_framing", framing, 0);
    step(); rst_n = 1'b1;

    // Full line, colour = column, sink always ready
    rdy_mode = 1;
    send_line(5'd7, COLS, 1, 0, 1'b1);
    drain("line7");
    chk("line7_overrun", overrun, 0);
    chk("line7_framing", framing, 0);

    // Same line with sink ready one cycle in three
    rdy_mode = 2;
    send_line(5'd7, COLS, 1, 0, 1'b1);
    drain("stall3");
    rdy_mode = 1;
    chk("stall3_framing", framing, 0);

    // Short line: column 19 keeps the previous line's value
    send_line(5'd2, 19, 1, 40, 1'b1);
    drain("short");
    chk("short_framing", framing, 1);
    chk("short_overrun", overrun, 0);

    // Long line: 21st pulse discarded
    do_reset();
    step(); #1;
    chk("long_pre_framing", framing, 0);
    send_line(5'd4, 21, 3, 1, 1'b1);
    drain("long");
    chk("long_framing", framing, 1);

    // Overrun: second latch while row 3 readout is stalled
    do_reset();
    rdy_mode = 0;
    send_line(5'd3, COLS, 1, 20, 1'b1);
    repeat (5) step();
    #1;
    chk("ovr_stalled_valid", wr_valid, 1);
    chk("ovr_pre", overrun, 0);
    send_line(5'd9, COLS, 1, 33, 1'b0);
    repeat (3) step();
    #1;
    chk("ovr_set", overrun, 1);
    chk("ovr_row_held", wr_row, 3);
    rdy_mode = 1;
    drain("ovr_row3");
    send_line(5'd5, COLS, 3, 7, 1'b1);
    drain("ovr_row5");
    chk("ovr_sticky", overrun, 1);
    chk("ovr_framing", framing, 0);

    // Driver-style stress over rows 0..31 and back to 0
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 33; i++) send_line(5'(i % 32), COLS, 1, i, 1'b1);
    drain("stress");
    chk("stress_overrun", overrun, 0);
    chk("stress_framing", framing, 0);

    // Reset in the middle of a readout
    send_line(5'd11, COLS, 5, 2, 1'b1);
    k = 0;
    found = 1'b0;
    while (!found && k < 200) begin
      step(); #2;
      if (wr_valid && wr_col == CW'(10)) found = 1'b1;
      k++;
    end
    chk("mid_col10", found, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", wr_valid, 0);
    chk("mid_rst_col", wr_col, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_framing", framing, 0);
    exp_q.delete();
    step(); step();
    rst_n = 1'b1;
    send_line(5'd12, COLS, 1, 9, 1'b1);
    drain("after_rst");
    chk("after_rst_framing", framing, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hub75_receiver.md
HUB75_RECEIVER -- requirements
Module: hub75_receiver

Interface
REQ-001 SHALL have parameter COLS, default 20, meaning data-clock pulses (pixel columns) per row line.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops on every panel-side input.
REQ-003 SHALL have port i_clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_data_clock  input  1  panel shift clock; pixel sampled on its rising edge.
REQ-006 SHALL have port i_data_latch  input  1  panel latch; rising edge commits the shifted line.
REQ-007 SHALL have port i_data_blank  input  1  panel blank (output-enable, high = dark).
REQ-008 SHALL have ports i_data_r, i_data_g, i_data_b  input  2 each  upper/lower half colour bits.
REQ-009 SHALL have port i_row_select  input  5  panel row address.
REQ-010 SHALL have ports o_wr_valid  output  1, i_wr_ready  input  1  pixel-write handshake.
REQ-011 SHALL have ports o_wr_row  output  5, o_wr_col  output  $clog2(COLS), o_wr_data  output  6 {r[1],g[1],b[1],r[0],g[0],b[0]}.
REQ-012 SHALL have ports o_blank  output  1 (synchronized blank), o_overrun  output  1, o_framing_err  output  1 (sticky flags).

Function
REQ-013 SHALL pass every panel input through SYNC_STAGES flops, then one edge-detect flop; colour and row use the same delay as clock/latch.
REQ-014 SHALL accept input levels lasting at least 1 i_clk cycle; rising edge of data_clock detected SYNC_STAGES+1 cycles after the input edge.
REQ-015 Capture: each detected data_clock rise with col_cnt < COLS SHALL write the synchronized 6-bit colour into line buffer entry col_cnt and increment col_cnt.
REQ-016 Capture: a data_clock rise with col_cnt == COLS SHALL be discarded, col_cnt held, o_framing_err set.
REQ-017 Latch rise SHALL sample synchronized row_select as the line's row and reset col_cnt to 0 in the same cycle.
REQ-018 Latch rise with col_cnt != COLS SHALL set o_framing_err; line is still committed (missing columns keep prior buffer contents).
REQ-019 Readout FSM states: S_IDLE, S_SEND. Latch rise in S_IDLE SHALL copy the line buffer to the readout buffer, set rd_col = 0, go to S_SEND next cycle.
REQ-020 S_SEND SHALL drive o_wr_valid=1, o_wr_row=committed row, o_wr_col=rd_col, o_wr_data=readout[rd_col].
REQ-021 o_wr_row/col/data SHALL stay stable while o_wr_valid && !i_wr_ready.
REQ-022 On o_wr_valid && i_wr_ready: rd_col < COLS-1 -> rd_col+1; rd_col == COLS-1 -> S_IDLE, o_wr_valid=0 next cycle.
REQ-023 Latch rise while in S_SEND SHALL drop the new line, leave the readout untouched, set o_overrun; capture of the next line proceeds normally.
REQ-024 Latch rise coincident with the final handshake SHALL count as S_SEND (dropped, o_overrun set).
REQ-025 Capture while S_SEND SHALL be allowed (separate line and readout buffers).
REQ-026 o_blank SHALL equal synchronized i_data_blank; blank does not gate capture or readout.
REQ-027 o_overrun, o_framing_err SHALL remain set until reset.
REQ-028 Latch held high SHALL commit once (rising edge only); data_clock rises during latch-high still captured.

Reset
REQ-029 i_rst_n low SHALL asynchronously clear: synchronizers, edge flops, col_cnt=0, rd_col=0, state=S_IDLE, o_wr_valid=0, o_wr_row=0, o_wr_col=0, o_wr_data=0, o_blank=0, o_overrun=0, o_framing_err=0.
REQ-030 Buffer contents SHALL be undefined after reset; no write is issued until a latch rise post-reset.
REQ-031 Reset asserted mid-line or mid-readout SHALL abandon the line; first post-reset write is column 0 of the next committed line.

Verification
REQ-032 20 data-clock pulses, colour = column index mod 64, row_select=7, latch rise, i_wr_ready=1 -> 20 writes, row 7, col 0..19, data matching, then o_wr_valid=0, no flags.
REQ-033 Same line, i_wr_ready toggled 1-of-3 cycles -> identical write sequence, outputs stable while stalled.
REQ-034 19 pulses then latch -> o_framing_err=1, 20 writes issued; 21 pulses then latch -> 20 writes with first 20 colours, o_framing_err=1.
REQ-035 Second latch arriving while i_wr_ready=0 during readout of row 3 -> o_overrun=1, only row 3 written; third line afterwards written normally.
REQ-036 Driver-pattern stress (1-cycle high/low data_clock, blank/latch/row sequence per line, rows 0..31 wrap) -> rows 0..31 then 0 written in order, o_blank tracks blank with SYNC_STAGES-cycle lag.
REQ-037 i_rst_n pulsed low at column 10 of readout -> o_wr_valid=0 immediately, flags 0, next line written from column 0.
